mem_rmw_port: RTL and testbench

Single-port memory responder that serves word reads and partial-word (bit-slice) writes over a valid/ready request/response channel. Partial writes run as read-modify-write against an internal synchronous-read array, so requesters never need a per-bit write enable. On reset it zero-fills the whole array. It sits between a requester (CPU-side or test driver) and a small register-file-style memory, and it is the serving end for the masked and part-select writes the converter emits.

---
 rtl/mem_rmw_pkg.sv | 40 ++++
 rtl/mem_rmw_sram.sv | 37 +++
 rtl/mem_rmw_port.sv | 164 ++++++++++++++++
 tb/tb_mem_rmw_port.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_rmw_pkg.sv
// mem_rmw_pkg: shared definitions for the read-modify-write memory port.
//   - geometry constants (DEPTH, ADDR_W, DATA_W, LEN_W, BASE_W)
//   - state_e: FSM state encoding
//   - slice_mask(base, len): bit mask covering the slice [base +: len]
//   - slice_err(base, len): 1 when the slice is empty or runs past the word
package mem_rmw_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int BASE_W = $clog2(DATA_W);
  localparam int MASK_W = DATA_W + LEN_W;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  // Built at DATA_W+LEN_W bits so (1<<len) cannot wrap for len up to DATA_W.
  function automatic logic [DATA_W-1:0] slice_mask(input logic [BASE_W-1:0] base,
                                                   input logic [LEN_W-1:0]  len);
    logic [MASK_W-1:0] ones;
    ones = (MASK_W'(1) << len) - MASK_W'(1);
    ones = ones << base;
    return ones[DATA_W-1:0];
  endfunction

  // base+len is formed one bit wider than len so it never wraps.
  function automatic logic slice_err(input logic [BASE_W-1:0] base,
                                     input logic [LEN_W-1:0]  len);
    logic [LEN_W:0] top;
    top = {1'b0, len} + (LEN_W+1)'(base);
    return (len == '0) || (top > (LEN_W+1)'(DATA_W));
  endfunction

endpackage

// File: rtl/mem_rmw_sram.sv
// mem_rmw_sram: single-port DEPTH x DATA_W array, synchronous read.
//   clk    clock
//   en     port enable (read or write this cycle)
//   we     1 = write wdata to addr, 0 = read addr
//   addr   word address
//   wdata  write data
//   rdata  read data, valid the cycle after a read; held while en=0
// The array itself has no reset; the owner clears it explicitly.
module mem_rmw_sram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_rmw_port.sv
// mem_rmw_port: valid/ready memory responder with word reads and
// read-modify-write slice writes. Zero-fills the array after reset.
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 = slice write, 0 = word read
//   req_addr            word address
//   req_base, req_len   slice LSB and width (writes only)
//   req_data            slice data, LSB-aligned
//   rsp_valid/ready     response handshake
//   rsp_data            read word, or word after (attempted) update
//   rsp_err             slice write rejected, array untouched
module mem_rmw_port
  import mem_rmw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BASE_W-1:0] req_base,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic [DATA_W-1:0] wr_mask, wr_new;
  logic              wr_err;

  mem_rmw_sram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Merge is evaluated in WR, when ram_rdata holds the old word read in RD.
  assign wr_mask = slice_mask(base_q, len_q);
  assign wr_err  = slice_err(base_q, len_q);
  assign wr_new  = (ram_rdata & ~wr_mask) | ((data_q << base_q) & wr_mask);

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    write_d    = write_q;
    addr_d     = addr_q;
    base_d     = base_q;
    len_d      = len_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_wdata  = '0;

    case (state_q)
      ST_CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_q;
        clr_d    = clr_q + ADDR_W'(1);
        if (clr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          base_d  = req_base;
          len_d   = req_len;
          data_d  = req_data;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        ram_en    = 1'b1;
        rsp_err_d = 1'b0;
        state_d   = write_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        if (!wr_err) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = wr_new;
        end
        rsp_data_d = wr_err ? ram_rdata : wr_new;
        rsp_err_d  = wr_err;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      len_q       <= len_d;
      data_q      <= data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // A read response is the SRAM output register itself; it is not re-enabled
  // in RESP, so it holds steady under backpressure.
  assign rsp_data  = (rsp_valid_q && !write_q) ? ram_rdata : rsp_data_q;

endmodule

// File: tb/tb_mem_rmw_port.sv
module tb_mem_rmw_port;
  import mem_rmw_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [BASE_W-1:0] req_base;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_rmw_port dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_base (req_base),
    .req_len  (req_len),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Release reset at a falling edge and confirm req_ready rises on the 16th edge.
  task automatic release_reset(input string tag);
    int early_ready;
    int early_valid;
    early_ready = 0;
    early_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      @(negedge clk);
      if (req_ready) early_ready++;
      if (rsp_valid) early_valid++;
    end
    check({tag, "_ready_early"}, early_ready, 0);
    check({tag, "_valid_clear"}, early_valid, 0);
    @(negedge clk);
    check({tag, "_ready_at_16"}, req_ready, 1);
    $display("reset release %s: req_ready=%0d after %0d cycles", tag, req_ready, DEPTH);
  endtask

  // One request/response. Called at a falling edge with the port idle.
  // hold = cycles to keep rsp_ready low once the response is up.
  task automatic xfer(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [BASE_W-1:0] base, input logic [LEN_W-1:0] len,
                      input logic [DATA_W-1:0] data, input int exp_lat,
                      input logic [DATA_W-1:0] exp_data, input logic exp_err, input int hold);
    int lat;
    int unstable;
    logic [DATA_W-1:0] d0;
    logic e0;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_base  = base;
    req_len   = len;
    req_data  = data;
    check({tag, "_req_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    $display("%s: wr=%0d addr=%0d base=%0d len=%0d data=0x%02h -> rsp_data=0x%02h err=%0d lat=%0d",
             tag, wr, addr, base, len, data, rsp_data, rsp_err, lat);
    if (hold > 0) begin
      d0 = rsp_data;
      e0 = rsp_err;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || req_ready) unstable++;
      end
      check({tag, "_hold_stable"}, unstable, 0);
      check({tag, "_hold_data"}, rsp_data, exp_data);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_valid_after"}, rsp_valid, 0);
  endtask

  initial begin
    int seen_valid;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_base  = '0;
    req_len   = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);

    release_reset("init");

    //   tag           wr    addr base len  data   lat exp    err hold
    xfer("rd5",        1'b0, 4'd5, 3'd0, 4'd0, 8'h00, 2, 8'h00, 0, 0);
    xfer("wr3_full",   1'b1, 4'd3, 3'd0, 4'd8, 8'hA5, 3, 8'hA5, 0, 0);
    xfer("rd3_a5",     1'b0, 4'd3, 3'd0, 4'd0, 8'h00, 2, 8'hA5, 0, 0);
    xfer("wr3_part",   1'b1, 4'd3, 3'd2, 4'd3, 8'hFF, 3, 8'hBD, 0, 0);
    xfer("rd3_bd",     1'b0, 4'd3, 3'd0, 4'd0, 8'h00, 2, 8'hBD, 0, 0);
    xfer("rd2_zero",   1'b0, 4'd2, 3'd0, 4'd0, 8'h00, 2, 8'h00, 0, 0);
    xfer("rd4_zero",   1'b0, 4'd4, 3'd0, 4'd0, 8'h00, 2, 8'h00, 0, 0);
    xfer("wr3_ovf",    1'b1, 4'd3, 3'd6, 4'd4, 8'h0F, 3, 8'hBD, 1, 0);
    xfer("wr3_len0",   1'b1, 4'd3, 3'd0, 4'd0, 8'h00, 3, 8'hBD, 1, 0);
    xfer("rd3_kept",   1'b0, 4'd3, 3'd0, 4'd0, 8'h00, 2, 8'hBD, 0, 0);
    // Exactly reaches the top bit: base 7 + len 1 == DATA_W is legal.
    xfer("wr3_top",    1'b1, 4'd3, 3'd7, 4'd1, 8'h00, 3, 8'h3D, 0, 0);
    xfer("rd3_bp",     1'b0, 4'd3, 3'd0, 4'd0, 8'h00, 2, 8'h3D, 0, 5);
    xfer("wr7_full",   1'b1, 4'd7, 3'd0, 4'd8, 8'h55, 3, 8'h55, 0, 0);

    // Reset while a write to addr 7 is in RD.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd7;
    req_base  = 3'd0;
    req_len   = 4'd8;
    req_data  = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, 0);
    check("midrst_valid", rsp_valid, 0);
    seen_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
    end
    check("midrst_no_rsp", seen_valid, 0);
    $display("reset mid-write: rsp_valid seen %0d times", seen_valid);
    release_reset("midrst");
    xfer("rd7_cleared", 1'b0, 4'd7, 3'd0, 4'd0, 8'h00, 2, 8'h00, 0, 0);
    xfer("rd3_cleared", 1'b0, 4'd3, 3'd0, 4'd0, 8'h00, 2, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
